// File: rtl/tekipaki_gp9001_host.sv
// GP9001 host command engine: decodes CPU op strobes into register and VRAM accesses and returns GP9001ACK.
// Optional VRAM_OK watchdog is compiled in with `define GP9001_HOST_TIMEOUT_EN.
module tekipaki_gp9001_host #(
    parameter int VRAM_AW     = 13,
    parameter int NREGS_LOG2  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                           CLK96,
    input  logic                           RESET96,
    input  logic                           OP_SELECT_REG,
    input  logic                           OP_WRITE_REG,
    input  logic                           OP_WRITE_RAM,
    input  logic                           OP_READ_RAM_H,
    input  logic                           OP_READ_RAM_L,
    input  logic                           OP_SET_RAM_PTR,
    input  logic [15:0]                    DIN,
    output logic                           ACK,
    output logic [15:0]                    DOUT,
    output logic [VRAM_AW-1:0]             VRAM_ADDR,
    output logic [15:0]                    VRAM_WDATA,
    output logic                           VRAM_WE,
    output logic                           VRAM_RD,
    input  logic [15:0]                    VRAM_Q,
    input  logic                           VRAM_OK,
    output logic [NREGS_LOG2-1:0]          REG_IDX,
    output logic [(16<<NREGS_LOG2)-1:0]    REGS,
    output logic                           TIMEOUT_ERR
);

`ifdef GP9001_HOST_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [VRAM_AW-1:0] ptr;
    logic               op_rd;
    logic               op_inc;
    logic [7:0]         tmo_cnt;
    logic               tmo_err;
    logic               any_op;
    logic               reg_op;
    logic               acc_tmo;

    assign any_op = OP_SET_RAM_PTR | OP_SELECT_REG | OP_WRITE_REG |
                    OP_WRITE_RAM | OP_READ_RAM_L | OP_READ_RAM_H;
    assign reg_op = OP_SET_RAM_PTR | OP_SELECT_REG | OP_WRITE_REG;

    // Watchdog fires on the last permitted ACCESS edge when VRAM_OK is still absent.
    assign acc_tmo = TMO_EN && (state == ACCESS) && !VRAM_OK && (tmo_cnt == TMO_LAST);
    assign TIMEOUT_ERR = TMO_EN & tmo_err;

    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_op) state_nxt = reg_op ? DONE : ACCESS;
            ACCESS:  if (VRAM_OK || acc_tmo) state_nxt = DONE;
            DONE:    if (!any_op) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            ACK        <= 1'b0;
            DOUT       <= '0;
            VRAM_ADDR  <= '0;
            VRAM_WDATA <= '0;
            VRAM_WE    <= 1'b0;
            VRAM_RD    <= 1'b0;
            REG_IDX    <= '0;
            REGS       <= '0;
            ptr        <= '0;
            op_rd      <= 1'b0;
            op_inc     <= 1'b0;
            tmo_cnt    <= '0;
            tmo_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (OP_SET_RAM_PTR) begin
                        ptr <= DIN[VRAM_AW-1:0];
                        ACK <= 1'b1;
                    end else if (OP_SELECT_REG) begin
                        REG_IDX <= DIN[NREGS_LOG2-1:0];
                        ACK     <= 1'b1;
                    end else if (OP_WRITE_REG) begin
                        REGS[int'(REG_IDX)*16 +: 16] <= DIN;
                        ACK <= 1'b1;
                    end else if (OP_WRITE_RAM) begin
                        VRAM_ADDR  <= ptr;
                        VRAM_WDATA <= DIN;
                        VRAM_WE    <= 1'b1;
                        op_rd      <= 1'b0;
                        op_inc     <= 1'b1;
                    end else if (OP_READ_RAM_L || OP_READ_RAM_H) begin
                        VRAM_ADDR <= ptr;
                        VRAM_RD   <= 1'b1;
                        op_rd     <= 1'b1;
                        op_inc    <= OP_READ_RAM_L;
                    end
                end
                ACCESS: begin
                    if (VRAM_OK || acc_tmo) begin
                        VRAM_WE <= 1'b0;
                        VRAM_RD <= 1'b0;
                        ACK     <= 1'b1;
                        if (op_rd)   DOUT <= VRAM_OK ? VRAM_Q : 16'hFFFF;
                        if (op_inc)  ptr  <= ptr + VRAM_AW'(1);
                        if (acc_tmo) tmo_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                DONE: begin
                    if (!any_op) ACK <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
